keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad. It drives one column at a time, samples the four row lines through a synchronizer and debounces both press and release. For each accepted key it emits one code with a single-cycle valid strobe. It sits between the keypad pins and the stopwatch/calculator control logic, and it replaces free-running combinational decoding with a sequenced scan.

---
 rtl/keypad_scan_ctrl_if.sv | 39 +++
 rtl/keypad_scan_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl_if
// Groups the keypad pin and key-event signals of the scan controller.
//   scan_en   : enables scanning; low parks the scanner in IDLE
//   row_n     : keypad row lines, active-low, asynchronous to the clock
//   col_n     : column drive, active-low one-hot, 4'b1111 = none driven
//   key_code  : code of the last accepted key
//   key_valid : single-cycle strobe when key_code updates
//   key_held  : high while the accepted key is pressed or release-debouncing
// Modports:
//   slave  : the scan controller itself
//   master : the surrounding logic / keypad pins that feed it
// -----------------------------------------------------------------------------
interface keypad_scan_ctrl_if;
   logic       scan_en;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport slave (
      input  scan_en,
      input  row_n,
      output col_n,
      output key_code,
      output key_valid,
      output key_held
   );

   modport master (
      output scan_en,
      output row_n,
      input  col_n,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// Sequenced scanner for a 4x4 matrix keypad. One column is driven low at a
// time, the row lines are synchronized and sampled after a settle time, and
// both press and release are debounced before a key is reported.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : keypad_scan_ctrl_if.slave (scan_en, row_n, col_n, key_code,
//           key_valid, key_held)
// Parameters:
//   SETTLE_CYC   : cycles a column is driven before rows are sampled (>= 4)
//   DEBOUNCE_CYC : consecutive stable cycles to accept a press or release
//   CNT_W        : width of the shared settle/debounce counter
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int SETTLE_CYC   = 16,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int CNT_W        = 20
) (
   input logic              clk,
   input logic              rst_n,
   keypad_scan_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_e;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_e           state_q;
   logic [1:0]       col_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       pat_q;
   logic [3:0]       sync1_q;
   logic [3:0]       rs_q;
   logic [3:0]       col_n_q;
   logic [3:0]       key_code_q;
   logic             key_valid_q;
   logic             key_held_q;

   logic [1:0]       col_d;
   logic             one_row_low;

   // Active-low drive pattern for a column index.
   function automatic logic [3:0] colDrive(input logic [1:0] idx);
      colDrive = ~(4'b0001 << idx);
   endfunction

   // Row index of the single low bit in a captured row pattern.
   function automatic logic [1:0] rowIndex(input logic [3:0] pat);
      case (pat)
         4'b1110: rowIndex = 2'd0;
         4'b1101: rowIndex = 2'd1;
         4'b1011: rowIndex = 2'd2;
         4'b0111: rowIndex = 2'd3;
         default: rowIndex = 2'd0;
      endcase
   endfunction

   // Physical keypad legend: star reports 15, hash reports 14.
   function automatic logic [3:0] keyMap(input logic [1:0] row, input logic [1:0] col);
      case ({row, col})
         4'h0: keyMap = 4'd1;
         4'h1: keyMap = 4'd2;
         4'h2: keyMap = 4'd3;
         4'h3: keyMap = 4'd10;
         4'h4: keyMap = 4'd4;
         4'h5: keyMap = 4'd5;
         4'h6: keyMap = 4'd6;
         4'h7: keyMap = 4'd11;
         4'h8: keyMap = 4'd7;
         4'h9: keyMap = 4'd8;
         4'hA: keyMap = 4'd9;
         4'hB: keyMap = 4'd12;
         4'hC: keyMap = 4'd15;
         4'hD: keyMap = 4'd0;
         4'hE: keyMap = 4'd14;
         default: keyMap = 4'd13;
      endcase
   endfunction

   // The column index is two bits wide so stepping past column 3 wraps to 0.
   assign col_d       = col_q + 2'd1;
   // Exactly one low row; two or more low rows indicate ghosting and are skipped.
   assign one_row_low = $onehot(~rs_q);

   // Two-flop synchronizer for the asynchronous row lines; idles high so
   // nothing looks pressed straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 4'b1111;
         rs_q    <= 4'b1111;
      end else begin
         sync1_q <= bus.row_n;
         rs_q    <= sync1_q;
      end
   end

   // Scan/debounce state machine. All outputs are registered here and change
   // together with the state, so key_valid rises in the first PRESSED cycle.
   // scan_en is only looked at on column boundaries and at the end of a
   // release so a press in progress always completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= 2'd0;
         cnt_q       <= '0;
         pat_q       <= 4'b1111;
         col_n_q     <= 4'b1111;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               col_n_q <= 4'b1111;
               cnt_q   <= '0;
               if (bus.scan_en) begin
                  state_q <= ST_SCAN;
                  col_q   <= 2'd0;
                  col_n_q <= colDrive(2'd0);
               end
            end

            ST_SCAN: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q <= '0;
                  if (one_row_low) begin
                     pat_q   <= rs_q;
                     state_q <= ST_DEBOUNCE;
                  end else if (!bus.scan_en) begin
                     state_q <= ST_IDLE;
                     col_n_q <= 4'b1111;
                  end else begin
                     col_q   <= col_d;
                     col_n_q <= colDrive(col_d);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            ST_DEBOUNCE: begin
               if (rs_q != pat_q) begin
                  state_q <= ST_SCAN;
                  cnt_q   <= '0;
                  col_q   <= col_d;
                  col_n_q <= colDrive(col_d);
               end else if (cnt_q == DEB_LAST) begin
                  state_q     <= ST_PRESSED;
                  cnt_q       <= '0;
                  key_code_q  <= keyMap(rowIndex(pat_q), col_q);
                  key_valid_q <= 1'b1;
                  key_held_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            ST_PRESSED: begin
               cnt_q <= '0;
               if (rs_q == 4'b1111) begin
                  state_q <= ST_RELEASE;
               end
            end

            ST_RELEASE: begin
               if (rs_q != 4'b1111) begin
                  state_q <= ST_PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  cnt_q      <= '0;
                  key_held_q <= 1'b0;
                  if (bus.scan_en) begin
                     state_q <= ST_SCAN;
                     col_q   <= col_d;
                     col_n_q <= colDrive(col_d);
                  end else begin
                     state_q <= ST_IDLE;
                     col_n_q <= 4'b1111;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               col_n_q <= 4'b1111;
            end
         endcase
      end
   end

   assign bus.col_n     = col_n_q;
   assign bus.key_code  = key_code_q;
   assign bus.key_valid = key_valid_q;
   assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl with SETTLE_CYC=4, DEBOUNCE_CYC=8.
// A small keypad model pulls row r low whenever key (r,c) is pressed and
// column c is driven; a separate glitch mask forces rows low directly.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic [15:0] pressed   = 16'h0000;
   logic [3:0]  glitchLow = 4'b0000;
   logic [3:0]  rowLow;

   int checks     = 0;
   int failures   = 0;
   int validCount = 0;

   keypad_scan_ctrl_if kif ();

   keypad_scan_ctrl #(
      .SETTLE_CYC  (4),
      .DEBOUNCE_CYC(8),
      .CNT_W       (20)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (kif.slave)
   );

   // 100 MHz-style free running clock; period is irrelevant to the design.
   always #5 clk = ~clk;

   // Keypad matrix model: key index is row*4 + column.
   always_comb begin
      rowLow = glitchLow;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !kif.col_n[c]) rowLow[r] = 1'b1;
         end
      end
   end
   assign kif.row_n = ~rowLow;

   // Counts every key_valid strobe, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n && kif.key_valid) validCount <= validCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keys, input logic [3:0] glitch);
      pressed   = keys;
      glitchLow = glitch;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waits for a key_valid strobe, bounded by maxCyc cycles.
   task automatic waitValid(input string tag, input int maxCyc);
      bit seen = 0;
      for (int i = 0; i < maxCyc && !seen; i++) begin
         tick(1);
         if (kif.key_valid) seen = 1;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   // Waits for the cycle in which col_n switches to pattern.
   task automatic waitColumn(input string tag, input logic [3:0] pattern, input int maxCyc);
      int  i = 0;
      bit  seen = 0;
      while (i < maxCyc && kif.col_n == pattern) begin
         tick(1);
         i++;
      end
      while (i < maxCyc && !seen) begin
         tick(1);
         i++;
         if (kif.col_n == pattern) seen = 1;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   task automatic waitHeldLow(input string tag, input int maxCyc);
      bit done = 0;
      for (int i = 0; i < maxCyc && !done; i++) begin
         tick(1);
         if (!kif.key_held) done = 1;
      end
      checkOutput(tag, 32'(done), 32'd1);
   endtask

   initial begin
      int vc0;
      kif.scan_en = 1'b0;

      // ---- Reset values ----
      #3 rst_n = 1'b0;
      #1;
      checkOutput("rst_col_n", 32'(kif.col_n), 32'hF);
      checkOutput("rst_code", 32'(kif.key_code), 32'h0);
      checkOutput("rst_valid", 32'(kif.key_valid), 32'h0);
      checkOutput("rst_held", 32'(kif.key_held), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      checkOutput("idle_no_en", 32'(kif.col_n), 32'hF);

      // ---- 1. Reset mid-DEBOUNCE with key 5 (r1c1) ----
      kif.scan_en = 1'b1;
      applyStimulus(16'h0020, 4'b0000);
      waitColumn("t1_col1", 4'b1101, 40);
      tick(6);
      checkOutput("t1_deb_col", 32'(kif.col_n), 32'hD);
      checkOutput("t1_deb_held", 32'(kif.key_held), 32'h0);
      #2;
      rst_n = 1'b0;
      kif.scan_en = 1'b0;
      #1;
      checkOutput("t1_rst_col_n", 32'(kif.col_n), 32'hF);
      checkOutput("t1_rst_valid", 32'(kif.key_valid), 32'h0);
      checkOutput("t1_rst_held", 32'(kif.key_held), 32'h0);
      checkOutput("t1_rst_code", 32'(kif.key_code), 32'h0);
      checkOutput("t1_no_strobe", 32'(validCount), 32'd0);
      applyStimulus(16'h0000, 4'b0000);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      checkOutput("t1_idle", 32'(kif.col_n), 32'hF);

      // ---- 2. Clean press r0c3 (A), held then released ----
      kif.scan_en = 1'b1;
      tick(3);
      vc0 = validCount;
      applyStimulus(16'h0008, 4'b0000);
      waitValid("t2_valid", 60);
      checkOutput("t2_code", 32'(kif.key_code), 32'd10);
      checkOutput("t2_held", 32'(kif.key_held), 32'h1);
      tick(25);
      checkOutput("t2_one_strobe", 32'(validCount - vc0), 32'd1);
      checkOutput("t2_col3", 32'(kif.col_n), 32'h7);
      checkOutput("t2_held_on", 32'(kif.key_held), 32'h1);
      applyStimulus(16'h0000, 4'b0000);
      tick(10);
      checkOutput("t2_held_rel", 32'(kif.key_held), 32'h1);
      tick(1);
      checkOutput("t2_held_drop", 32'(kif.key_held), 32'h0);
      checkOutput("t2_resume_c0", 32'(kif.col_n), 32'hE);
      checkOutput("t2_total", 32'(validCount - vc0), 32'd1);

      // ---- 3. Bouncing r3c2 (#), then held ----
      vc0 = validCount;
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i % 2 == 0) ? 16'h4000 : 16'h0000, 4'b0000);
         tick(3);
      end
      checkOutput("t3_no_bounce", 32'(validCount - vc0), 32'd0);
      applyStimulus(16'h4000, 4'b0000);
      waitValid("t3_valid", 60);
      checkOutput("t3_code", 32'(kif.key_code), 32'd14);
      tick(5);
      checkOutput("t3_one_strobe", 32'(validCount - vc0), 32'd1);
      applyStimulus(16'h0000, 4'b0000);
      waitHeldLow("t3_release", 30);

      // ---- 4. Ghosting: r1c0 and r2c0 together ----
      vc0 = validCount;
      applyStimulus(16'h0110, 4'b0000);
      waitColumn("t4_col0", 4'b1110, 40);
      tick(3);
      checkOutput("t4_still_c0", 32'(kif.col_n), 32'hE);
      tick(1);
      checkOutput("t4_adv_c1", 32'(kif.col_n), 32'hD);
      checkOutput("t4_no_strobe", 32'(validCount - vc0), 32'd0);
      checkOutput("t4_no_held", 32'(kif.key_held), 32'h0);
      applyStimulus(16'h0000, 4'b0000);
      tick(4);

      // ---- 5. Release bounce on key 5 ----
      vc0 = validCount;
      applyStimulus(16'h0020, 4'b0000);
      waitValid("t5_valid", 60);
      checkOutput("t5_code", 32'(kif.key_code), 32'd5);
      tick(3);
      applyStimulus(16'h0000, 4'b0000);
      tick(5);
      applyStimulus(16'h0000, 4'b0010);
      tick(2);
      applyStimulus(16'h0000, 4'b0000);
      tick(5);
      checkOutput("t5_held_mid", 32'(kif.key_held), 32'h1);
      tick(5);
      checkOutput("t5_held_late", 32'(kif.key_held), 32'h1);
      tick(1);
      checkOutput("t5_held_drop", 32'(kif.key_held), 32'h0);
      checkOutput("t5_one_strobe", 32'(validCount - vc0), 32'd1);

      // ---- 6. scan_en dropped during column 2 ----
      waitColumn("t6_col2", 4'b1011, 40);
      kif.scan_en = 1'b0;
      tick(3);
      checkOutput("t6_col2_hold", 32'(kif.col_n), 32'hB);
      tick(1);
      checkOutput("t6_idle", 32'(kif.col_n), 32'hF);
      tick(3);
      checkOutput("t6_idle_stay", 32'(kif.col_n), 32'hF);
      kif.scan_en = 1'b1;
      tick(1);
      checkOutput("t6_restart_c0", 32'(kif.col_n), 32'hE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
